// File: rtl/myip123_axi_pkg.sv
// Shared AXI4 encodings, FSM state types and the burst legality check
// used by the burst slave memory.
package myip123_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4_BYTES = 3'b010;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // Only full-word beats, defined burst types and power-of-two wrap lengths are served.
  function automatic logic burst_illegal(input logic [2:0] size,
                                         input logic [1:0] burst,
                                         input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != SIZE_4_BYTES) || (burst == 2'b11) ||
           ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_burst_addr_next.sv
// Next-beat byte address for FIXED / INCR / WRAP bursts of 4-byte beats.
module axi_burst_addr_next
  import myip123_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] addr_next
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] mask;

  always_comb begin
    incr = addr + ADDR_WIDTH'(4);
    // (len+1)*4-1 is simply len with two ones appended.
    mask = ADDR_WIDTH'({len, 2'b11});
    unique case (burst)
      BURST_FIXED: addr_next = addr;
      BURST_WRAP:  addr_next = (addr & ~mask) | (incr & mask);
      default:     addr_next = incr;
    endcase
  end

endmodule

// File: rtl/axi4_burst_slave_mem.sv
// AXI4 slave backed by a word-addressed register memory; one write burst
// and one read burst may be in flight at the same time.
module axi4_burst_slave_mem
  import myip123_axi_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 4,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_MEM_WORDS        = 64
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]                    AWLEN,
  input  logic [2:0]                    AWSIZE,
  input  logic [1:0]                    AWBURST,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [31:0]                   WDATA,
  input  logic [3:0]                    WSTRB,
  input  logic                          WLAST,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   BID,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]                    ARLEN,
  input  logic [2:0]                    ARSIZE,
  input  logic [1:0]                    ARBURST,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   RID,
  output logic [31:0]                   RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RLAST,
  output logic                          RVALID,
  input  logic                          RREADY
);

  localparam int IDX_W = $clog2(C_MEM_WORDS);

  logic [31:0] mem [C_MEM_WORDS];

  // ---------------- write path ----------------
  wr_state_t                     wr_state, wr_next;
  logic [C_S_AXI_ID_WIDTH-1:0]   wid;
  logic [C_S_AXI_ADDR_WIDTH-1:0] waddr, waddr_nxt;
  logic [7:0]                    wlen;
  logic [1:0]                    wburst;
  logic [8:0]                    wbeat;
  logic                          werr;
  logic                          aw_fire, w_fire, mem_we;

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign mem_we  = w_fire && !werr && (wbeat <= {1'b0, wlen});

  axi_burst_addr_next #(.ADDR_WIDTH(C_S_AXI_ADDR_WIDTH)) u_waddr_next (
    .addr(waddr), .len(wlen), .burst(wburst), .addr_next(waddr_nxt)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (ARESET) wr_state <= W_IDLE;
    else        wr_state <= wr_next;
  end

  always_comb begin
    // NOTE: every output gets a default up front so no path through the case
    // leaves a signal unassigned and infers a latch.
    wr_next = wr_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BRESP   = RESP_OKAY;
    unique case (wr_state)
      W_IDLE: if (AWVALID) wr_next = W_DATA;
      W_DATA: if (WVALID && WLAST) wr_next = W_RESP;
      W_RESP: if (BREADY) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
    // Handshake outputs are held low for the whole reset window.
    if (!ARESET) begin
      AWREADY = (wr_state == W_IDLE);
      WREADY  = (wr_state == W_DATA);
      BVALID  = (wr_state == W_RESP);
      BRESP   = (wr_state == W_RESP && werr) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wid    <= '0;
      waddr  <= '0;
      wlen   <= '0;
      wburst <= '0;
      wbeat  <= '0;
      werr   <= 1'b0;
    end else if (aw_fire) begin
      wid    <= AWID;
      waddr  <= AWADDR;
      wlen   <= AWLEN;
      wburst <= AWBURST;
      wbeat  <= '0;
      werr   <= burst_illegal(AWSIZE, AWBURST, AWLEN);
    end else if (w_fire) begin
      waddr <= waddr_nxt;
      wbeat <= wbeat + 9'd1;
      if (WLAST && (wbeat != {1'b0, wlen})) werr <= 1'b1;
    end
  end

  assign BID = wid;

  // NOTE: the memory array has no reset; its contents are undefined until
  // written, which keeps it a plain RAM-style register file.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (WSTRB[b]) mem[waddr[IDX_W+1:2]][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rd_state_t                     rd_state, rd_next;
  logic [C_S_AXI_ADDR_WIDTH-1:0] raddr, raddr_nxt;
  logic [7:0]                    rlen, rbeat;
  logic [1:0]                    rburst;
  logic                          rerr, ar_err, ar_fire, r_fire;

  assign ar_fire = ARVALID && ARREADY;
  assign r_fire  = RVALID && RREADY;
  assign ar_err  = burst_illegal(ARSIZE, ARBURST, ARLEN);

  axi_burst_addr_next #(.ADDR_WIDTH(C_S_AXI_ADDR_WIDTH)) u_raddr_next (
    .addr(raddr), .len(rlen), .burst(rburst), .addr_next(raddr_nxt)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rd_state <= R_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    unique case (rd_state)
      R_IDLE: if (ARVALID) rd_next = R_DATA;
      R_DATA: if (RREADY && RLAST) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
    if (!ARESET) begin
      ARREADY = (rd_state == R_IDLE);
      RVALID  = (rd_state == R_DATA);
    end
  end

  // RDATA is registered straight from the array, so a same-edge write is not seen.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      RID    <= '0;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
      RLAST  <= 1'b0;
      raddr  <= '0;
      rlen   <= '0;
      rburst <= '0;
      rbeat  <= '0;
      rerr   <= 1'b0;
    end else if (ar_fire) begin
      RID    <= ARID;
      RDATA  <= ar_err ? 32'd0 : mem[ARADDR[IDX_W+1:2]];
      RRESP  <= ar_err ? RESP_SLVERR : RESP_OKAY;
      RLAST  <= (ARLEN == 8'd0);
      raddr  <= ARADDR;
      rlen   <= ARLEN;
      rburst <= ARBURST;
      rbeat  <= '0;
      rerr   <= ar_err;
    end else if (r_fire && !RLAST) begin
      RDATA <= rerr ? 32'd0 : mem[raddr_nxt[IDX_W+1:2]];
      RLAST <= ((rbeat + 8'd1) == rlen);
      raddr <= raddr_nxt;
      rbeat <= rbeat + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
// Directed bench for axi4_burst_slave_mem: a reference memory model feeds
// expected B and R results into queues that are popped as the DUT responds.
module tb_axi4_burst_slave_mem;
  import myip123_axi_pkg::*;

  localparam int IDW   = 4;
  localparam int AW    = 32;
  localparam int WORDS = 64;

  logic           tb_ACLK = 1'b0;
  logic           ARESET;
  logic [IDW-1:0] AWID, ARID, BID, RID;
  logic [AW-1:0]  AWADDR, ARADDR;
  logic [7:0]     AWLEN, ARLEN;
  logic [2:0]     AWSIZE, ARSIZE;
  logic [1:0]     AWBURST, ARBURST, BRESP, RRESP;
  logic           AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic           ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0]    WDATA, RDATA;
  logic [3:0]     WSTRB;

  always #5 tb_ACLK = ~tb_ACLK;

  axi4_burst_slave_mem #(
    .C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_ADDR_WIDTH(AW), .C_MEM_WORDS(WORDS)
  ) dut (
    .ACLK(tb_ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
  } b_exp_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    logic [1:0]     resp;
    logic           last;
  } r_exp_t;

  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  logic [31:0] model   [WORDS];
  logic [31:0] tx_data [256];
  logic [3:0]  tx_strb [256];
  logic [31:0] rx_data [256];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_next(input logic [31:0] a, input logic [7:0] len,
                                         input logic [1:0] burst);
    logic [31:0] span, base;
    case (burst)
      2'b00: return a;
      2'b10: begin
        span = (32'(len) + 32'd1) * 32'd4;
        base = a - (a % span);
        return base + ((a + 32'd4 - base) % span);
      end
      default: return a + 32'd4;
    endcase
  endfunction

  function automatic logic m_err(input logic [2:0] size, input logic [1:0] burst,
                                 input logic [7:0] len);
    return (size != 3'b010) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % 32'(WORDS));
  endfunction

  task automatic write_burst(input logic [IDW-1:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int bready_delay);
    logic           err;
    logic [31:0]    a;
    logic [IDW-1:0] bid_seen;
    b_exp_t         e;
    int             n, k;
    err = m_err(size, burst, len);
    a   = addr;
    for (int i = 0; i <= int'(len); i++) begin
      k = m_idx(a);
      if (!err)
        for (int b = 0; b < 4; b++)
          if (tx_strb[i][b]) model[k][8*b +: 8] = tx_data[i][8*b +: 8];
      a = m_next(a, len, burst);
    end
    b_q.push_back('{id, err ? 2'b10 : 2'b00});

    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 100) begin @(posedge tb_ACLK); #1; n++; end
    check("awready_wait", AWREADY, 1);
    @(posedge tb_ACLK); #1;
    AWVALID = 1'b0;
    check("wready_after_aw", WREADY, 1);

    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1'b1; WDATA = tx_data[i]; WSTRB = tx_strb[i]; WLAST = (i == int'(len));
      n = 0;
      while (!WREADY && n < 100) begin @(posedge tb_ACLK); #1; n++; end
      @(posedge tb_ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;

    check("bvalid_after_wlast", BVALID, 1);
    e = b_q.pop_front();
    check("bid", BID, e.id);
    check("bresp", BRESP, e.resp);
    bid_seen = BID;
    for (int d = 0; d < bready_delay; d++) begin
      @(posedge tb_ACLK); #1;
      check("bvalid_hold", BVALID, 1);
      check("bid_hold", BID, bid_seen);
    end
    BREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    BREADY = 1'b0;
    check("bvalid_drop", BVALID, 0);
  endtask

  // Receives up to stop_after beats; a smaller stop_after leaves the burst open.
  task automatic read_burst(input logic [IDW-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input bit toggle, input int stop_after);
    logic        err, rr;
    logic [31:0] a;
    int          n, beats, cyc;
    err = m_err(size, burst, len);
    a   = addr;
    for (int b = 0; b <= int'(len); b++) begin
      r_q.push_back('{id, err ? 32'd0 : model[m_idx(a)], err ? 2'b10 : 2'b00, b == int'(len)});
      a = m_next(a, len, burst);
    end

    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 100) begin @(posedge tb_ACLK); #1; n++; end
    check("arready_wait", ARREADY, 1);
    @(posedge tb_ACLK); #1;
    ARVALID = 1'b0;
    check("rvalid_after_ar", RVALID, 1);

    beats = 0;
    cyc   = 0;
    while (beats <= int'(len) && beats < stop_after && cyc < 2000) begin
      rr = toggle ? (cyc % 2 == 1) : 1'b1;
      RREADY = rr;
      check("rvalid_hold", RVALID, 1);
      check("rid", RID, r_q[0].id);
      check("rdata", RDATA, r_q[0].data);
      check("rresp", RRESP, r_q[0].resp);
      check("rlast", RLAST, r_q[0].last);
      if (rr) begin
        rx_data[beats] = RDATA;
        r_q.delete(0);
        beats++;
      end
      @(posedge tb_ACLK); #1;
      cyc++;
    end
    RREADY = 1'b0;
    if (stop_after > int'(len)) begin
      check("r_beat_count", beats, 32'(len) + 32'd1);
      check("rvalid_end", RVALID, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, AWREADY, 0);
    check({tag, "_wready"},  WREADY, 0);
    check({tag, "_arready"}, ARREADY, 0);
    check({tag, "_bvalid"},  BVALID, 0);
    check({tag, "_rvalid"},  RVALID, 0);
    check({tag, "_bid_rid"}, {BID, RID}, 0);
    check({tag, "_rdata"},   RDATA, 0);
    check({tag, "_resps"},   {BRESP, RRESP}, 0);
    check({tag, "_rlast"},   RLAST, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    repeat (3) @(posedge tb_ACLK);
    #1;
    check_all_zero("reset");
    ARESET = 1'b0;
    @(posedge tb_ACLK); #1;
    check("awready_after_reset", AWREADY, 1);
    check("arready_after_reset", ARREADY, 1);

    // INCR 16-beat write, then WRAP LEN=15 read of the same block
    for (int i = 0; i < 16; i++) begin
      tx_data[i] = (i == 15) ? 32'hFFFF_FFFF : 32'h00ab_cdef + 32'(i) * 32'h1111_1111;
      tx_strb[i] = 4'hF;
    end
    write_burst(4'd1, 32'h0, 8'd15, 3'b010, 2'b01, 0);
    read_burst(4'd2, 32'h0, 8'd15, 3'b010, 2'b10, 1'b0, 256);
    check("incr_wrap_beat0", rx_data[0], 32'h00ab_cdef);
    check("incr_wrap_beat15", rx_data[15], 32'hFFFF_FFFF);

    // WRAP ordering starting mid-window
    for (int i = 0; i < 4; i++) begin
      tx_data[i] = 32'hA0 + 32'(i);
      tx_strb[i] = 4'hF;
    end
    write_burst(4'd3, 32'h0, 8'd3, 3'b010, 2'b01, 0);
    read_burst(4'd4, 32'h8, 8'd3, 3'b010, 2'b10, 1'b0, 256);
    check("wrap_order0", rx_data[0], 32'hA2);
    check("wrap_order1", rx_data[1], 32'hA3);
    check("wrap_order2", rx_data[2], 32'hA0);
    check("wrap_order3", rx_data[3], 32'hA1);

    // Partial byte strobes
    tx_data[0] = 32'hFFFF_FFFF; tx_strb[0] = 4'hF;
    write_burst(4'd5, 32'h40, 8'd0, 3'b010, 2'b01, 0);
    tx_data[0] = 32'h1234_5678; tx_strb[0] = 4'b0101;
    write_burst(4'd6, 32'h40, 8'd0, 3'b010, 2'b01, 0);
    read_burst(4'd7, 32'h40, 8'd0, 3'b010, 2'b01, 1'b0, 256);
    check("partial_strobe", rx_data[0], 32'hFF34_FF78);

    // FIXED burst: both beats land on one word, last one wins
    tx_data[0] = 32'h11; tx_data[1] = 32'h22; tx_strb[0] = 4'hF; tx_strb[1] = 4'hF;
    write_burst(4'd8, 32'hC0, 8'd1, 3'b010, 2'b00, 0);
    read_burst(4'd9, 32'hC0, 8'd0, 3'b010, 2'b01, 1'b0, 256);
    check("fixed_last_wins", rx_data[0], 32'h22);

    // Backpressure on B and R
    tx_data[0] = 32'hCAFE_0001; tx_data[1] = 32'hCAFE_0002;
    write_burst(4'hA, 32'h80, 8'd1, 3'b010, 2'b01, 5);
    read_burst(4'hB, 32'h0, 8'd7, 3'b010, 2'b01, 1'b1, 256);

    // Illegal size on write, illegal wrap length on read
    tx_data[0] = 32'hDEAD_BEEF; tx_strb[0] = 4'hF;
    write_burst(4'hC, 32'h40, 8'd0, 3'b001, 2'b01, 0);
    read_burst(4'hD, 32'h40, 8'd0, 3'b010, 2'b01, 1'b0, 256);
    check("err_write_no_effect", rx_data[0], 32'hFF34_FF78);
    read_burst(4'hE, 32'h0, 8'd2, 3'b010, 2'b10, 1'b0, 256);

    // Reset during beat 5 of a 16-beat read
    read_burst(4'h3, 32'h0, 8'd15, 3'b010, 2'b01, 1'b0, 5);
    check("midburst_rvalid", RVALID, 1);
    ARESET = 1'b1;
    #1;
    check_all_zero("midreset");
    r_q.delete();
    @(posedge tb_ACLK); #1;
    ARESET = 1'b0;
    #1;
    check("arready_after_midreset", ARREADY, 1);
    tx_data[0] = 32'h5A5A_0F0F; tx_strb[0] = 4'hF;
    write_burst(4'h2, 32'h10, 8'd0, 3'b010, 2'b01, 0);
    read_burst(4'h5, 32'h10, 8'd0, 3'b010, 2'b01, 1'b0, 256);
    check("post_reset_read", rx_data[0], 32'h5A5A_0F0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
